secuenciador_instrucciones: RTL and testbench

SECUENCIADOR_INSTRUCCIONES -- requirements
Module: secuenciador_instrucciones

---
 rtl/secuenciador_instrucciones.sv | 216 +++++++++++++++++++++
 tb/tb_secuenciador_instrucciones.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/secuenciador_instrucciones.sv
// rtl/secuenciador_instrucciones.sv - control sequencer for a 16-bit load/store CPU
//
// Purpose: walks each instruction through fetch, decode and the extra memory
// cycles that loads and stores need. It emits the next control-register value,
// the register-file, PC, AR and DR load/select strobes and the ALSU function.
// All outputs are combinational functions of the current state and the IR.
//
// Ports:
//   Reloj        in   system clock; state advances on the rising edge
//   Reiniciar    in   asynchronous active-low reset; while low every output is 0
//   Instruccion  in   IR: [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb
//   Control      out  next CR value {oeM,oePCd,oeDR,oePCa,oeAR,WR}
//   LoadSelect   out  {SelectDR,LoadDR,SelectAR,LoadAR,SelectPC[1:0],LoadPC,
//                      LoadIR,LoadCR,WriteSelect,WriteEnable}
//   WriteAddress out  register-bank write address
//   ReadAddressA out  register-bank read port A address
//   ReadAddressB out  register-bank read port B address
//   Fun          out  ALSU function select
//   Estado       out  current state code
//   Detenido     out  high only while halted

module secuenciador_instrucciones #(
   parameter logic [3:0] FUN_PASA_A = 4'b1000
) (
   input  logic        Reloj,
   input  logic        Reiniciar,
   input  logic [15:0] Instruccion,
   output logic [5:0]  Control,
   output logic [10:0] LoadSelect,
   output logic [2:0]  WriteAddress,
   output logic [2:0]  ReadAddressA,
   output logic [2:0]  ReadAddressB,
   output logic [3:0]  Fun,
   output logic [2:0]  Estado,
   output logic        Detenido
);

   typedef enum logic [2:0] {
      BUSCA0  = 3'd0,
      BUSCA1  = 3'd1,
      DECOD   = 3'd2,
      CARGA1  = 3'd3,
      GUARDA1 = 3'd4,
      GUARDA2 = 3'd5,
      ALTO    = 3'd6
   } estado_t;

   // Control register bit masks
   localparam logic [5:0] C_OEM   = 6'b100000;
   localparam logic [5:0] C_OEDR  = 6'b001000;
   localparam logic [5:0] C_OEPCA = 6'b000100;
   localparam logic [5:0] C_OEAR  = 6'b000010;
   localparam logic [5:0] C_WR    = 6'b000001;

   estado_t state_q, state_d;

   logic [3:0] opcode;
   logic [2:0] rd, ra, rb;
   logic       unused_bits;

   logic [5:0] ctl;
   logic       sel_dr, ld_dr, sel_ar, ld_ar, ld_pc, ld_ir, ld_cr, wr_sel, wr_en;
   logic [1:0] sel_pc;
   logic [2:0] wa, xa, xb, est;
   logic [3:0] fn;
   logic       det;

   assign opcode      = Instruccion[15:12];
   assign rd          = Instruccion[11:9];
   assign ra          = Instruccion[8:6];
   assign rb          = Instruccion[5:3];
   assign unused_bits = ^Instruccion[2:0];

   always_ff @(posedge Reloj or negedge Reiniciar) begin
      if (!Reiniciar) begin
         state_q <= BUSCA0;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ctl     = '0;
      sel_dr  = 1'b0;
      ld_dr   = 1'b0;
      sel_ar  = 1'b0;
      ld_ar   = 1'b0;
      sel_pc  = 2'b00;
      ld_pc   = 1'b0;
      ld_ir   = 1'b0;
      ld_cr   = 1'b0;
      wr_sel  = 1'b0;
      wr_en   = 1'b0;
      wa      = '0;
      xa      = '0;
      xb      = '0;
      fn      = '0;
      est     = state_q;
      det     = 1'b0;

      case (state_q)
         BUSCA0: begin
            // PC onto the address bus and memory onto the data bus next cycle
            ctl     = C_OEPCA | C_OEM;
            ld_cr   = 1'b1;
            state_d = BUSCA1;
         end
         BUSCA1: begin
            // Instruction word is on the bus now; capture it and bump PC
            ld_ir   = 1'b1;
            sel_pc  = 2'b11;
            ld_pc   = 1'b1;
            ld_cr   = 1'b1;
            state_d = DECOD;
         end
         DECOD: begin
            state_d = BUSCA0;
            if (!opcode[3]) begin
               xa    = ra;
               xb    = rb;
               fn    = {1'b0, opcode[2:0]};
               wr_en = 1'b1;
               wa    = rd;
            end else begin
               case (opcode)
                  4'h8: begin
                     xa      = ra;
                     fn      = FUN_PASA_A;
                     sel_ar  = 1'b1;
                     ld_ar   = 1'b1;
                     ctl     = C_OEAR | C_OEM;
                     ld_cr   = 1'b1;
                     state_d = CARGA1;
                  end
                  4'h9: begin
                     xa      = ra;
                     fn      = FUN_PASA_A;
                     sel_ar  = 1'b1;
                     ld_ar   = 1'b1;
                     ctl     = C_OEAR;
                     ld_cr   = 1'b1;
                     state_d = GUARDA1;
                  end
                  4'hA: begin
                     xa     = ra;
                     fn     = FUN_PASA_A;
                     sel_pc = 2'b01;
                     ld_pc  = 1'b1;
                  end
                  4'hF: state_d = ALTO;
                  default: ;
               endcase
            end
         end
         CARGA1: begin
            // Memory data is on the bus; write it into rd
            wr_sel  = 1'b1;
            wr_en   = 1'b1;
            wa      = rd;
            ld_cr   = 1'b1;
            state_d = BUSCA0;
         end
         GUARDA1: begin
            // Route R[rb] through the ALSU into DR, then request the write
            xa      = rb;
            fn      = FUN_PASA_A;
            sel_dr  = 1'b1;
            ld_dr   = 1'b1;
            ctl     = C_OEAR | C_OEDR | C_WR;
            ld_cr   = 1'b1;
            state_d = GUARDA2;
         end
         GUARDA2: begin
            ld_cr   = 1'b1;
            state_d = BUSCA0;
         end
         ALTO: begin
            det     = 1'b1;
            state_d = ALTO;
         end
         default: state_d = BUSCA0;
      endcase

      // Reset must silence every strobe at once, not on the next edge
      if (!Reiniciar) begin
         ctl    = '0;
         sel_dr = 1'b0;
         ld_dr  = 1'b0;
         sel_ar = 1'b0;
         ld_ar  = 1'b0;
         sel_pc = 2'b00;
         ld_pc  = 1'b0;
         ld_ir  = 1'b0;
         ld_cr  = 1'b0;
         wr_sel = 1'b0;
         wr_en  = 1'b0;
         wa     = '0;
         xa     = '0;
         xb     = '0;
         fn     = '0;
         est    = '0;
         det    = 1'b0;
      end
   end

   assign Control      = ctl;
   assign LoadSelect   = {sel_dr, ld_dr, sel_ar, ld_ar, sel_pc, ld_pc, ld_ir, ld_cr, wr_sel, wr_en};
   assign WriteAddress = wa;
   assign ReadAddressA = xa;
   assign ReadAddressB = xb;
   assign Fun          = fn;
   assign Estado       = est;
   assign Detenido     = det;

endmodule

// File: tb/tb_secuenciador_instrucciones.sv
// tb/tb_secuenciador_instrucciones.sv - self-checking bench for secuenciador_instrucciones

module tb_secuenciador_instrucciones;

   logic        Reloj;
   logic        Reiniciar;
   logic [15:0] Instruccion;
   logic [5:0]  Control;
   logic [10:0] LoadSelect;
   logic [2:0]  WriteAddress, ReadAddressA, ReadAddressB;
   logic [3:0]  Fun;
   logic [2:0]  Estado;
   logic        Detenido;

   int n_assert = 0;
   int n_fail   = 0;

   logic [33:0] obs;
   assign obs = {Estado, Control, LoadSelect, WriteAddress, ReadAddressA, ReadAddressB, Fun, Detenido};

   // LoadSelect bit positions
   localparam int SDR = 10, LDR = 9, SAR = 8, LAR = 7, LPC = 4, LIR = 3, LCR = 2, WSL = 1, WEN = 0;
   localparam logic [3:0] PASA_A = 4'b1000;

   secuenciador_instrucciones dut (
      .Reloj        (Reloj),
      .Reiniciar    (Reiniciar),
      .Instruccion  (Instruccion),
      .Control      (Control),
      .LoadSelect   (LoadSelect),
      .WriteAddress (WriteAddress),
      .ReadAddressA (ReadAddressA),
      .ReadAddressB (ReadAddressB),
      .Fun          (Fun),
      .Estado       (Estado),
      .Detenido     (Detenido)
   );

   initial Reloj = 1'b0;
   always #5 Reloj = ~Reloj;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Cycles from BUSCA0 entry to the next BUSCA0 entry (HLT: to ALTO entry)
   function automatic int ncyc(input logic [15:0] ir);
      case (ir[15:12])
         4'h8:    return 4;
         4'h9:    return 5;
         default: return 3;
      endcase
   endfunction

   // Expected outputs in cycle k of an instruction's schedule
   function automatic logic [33:0] exp_vec(input int k, input logic [15:0] ir);
      logic [3:0]  op;
      logic [2:0]  rd, ra, rb, est, wa, xa, xb;
      logic [5:0]  ctl;
      logic [10:0] ls;
      logic [3:0]  fn;
      op = ir[15:12]; rd = ir[11:9]; ra = ir[8:6]; rb = ir[5:3];
      est = 3'd0; wa = '0; xa = '0; xb = '0; ctl = '0; ls = '0; fn = '0;
      if (k == 0) begin
         ctl = 6'b100100; ls[LCR] = 1'b1;
      end else if (k == 1) begin
         est = 3'd1; ls[LIR] = 1'b1; ls[LPC] = 1'b1; ls[6:5] = 2'b11; ls[LCR] = 1'b1;
      end else if (k == 2) begin
         est = 3'd2;
         if (op < 4'h8) begin
            xa = ra; xb = rb; fn = {1'b0, op[2:0]}; ls[WEN] = 1'b1; wa = rd;
         end else if (op == 4'h8) begin
            xa = ra; fn = PASA_A; ls[SAR] = 1'b1; ls[LAR] = 1'b1; ctl = 6'b100010; ls[LCR] = 1'b1;
         end else if (op == 4'h9) begin
            xa = ra; fn = PASA_A; ls[SAR] = 1'b1; ls[LAR] = 1'b1; ctl = 6'b000010; ls[LCR] = 1'b1;
         end else if (op == 4'hA) begin
            xa = ra; fn = PASA_A; ls[6:5] = 2'b01; ls[LPC] = 1'b1;
         end
      end else if (k == 3 && op == 4'h8) begin
         est = 3'd3; ls[WSL] = 1'b1; ls[WEN] = 1'b1; wa = rd; ls[LCR] = 1'b1;
      end else if (k == 3) begin
         est = 3'd4; xa = rb; fn = PASA_A; ls[SDR] = 1'b1; ls[LDR] = 1'b1; ctl = 6'b001011; ls[LCR] = 1'b1;
      end else begin
         est = 3'd5; ls[LCR] = 1'b1;
      end
      return {est, ctl, ls, wa, xa, xb, fn, 1'b0};
   endfunction

   task automatic chk(input logic [33:0] expv, input string tag);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Starts at posedge+1 with the DUT in BUSCA0; runs up to lim cycles
   task automatic run(input logic [15:0] ir, input int lim, input string tag);
      int n;
      logic [3:0] op;
      n  = ncyc(ir);
      op = ir[15:12];
      for (int k = 0; k < n && k < lim; k++) begin
         // IR only matters where the sequencer decodes it; elsewhere it is noise
         if (k == 2 || (k == 3 && (op == 4'h8 || op == 4'h9)))
            Instruccion = ir;
         else
            Instruccion = 16'($urandom);
         @(negedge Reloj);
         chk(exp_vec(k, ir), $sformatf("%s_c%0d_ir%h", tag, k, ir));
         @(posedge Reloj); #1;
      end
      if (lim >= n) begin
         n_assert++;
         assert (Estado === ((op == 4'hF) ? 3'd6 : 3'd0)) else begin
            n_fail++;
            $error("FAIL %s_cycle_count ir=%h observed_estado=%0d expected=%0d",
                   tag, ir, Estado, (op == 4'hF) ? 6 : 0);
         end
      end
   endtask

   initial begin
      logic [15:0] ir;
      logic [33:0] halted;
      halted = {3'd6, 30'd0, 1'b1};

      Reiniciar   = 1'b0;
      Instruccion = 16'($urandom);
      #2;
      chk('0, "reset_state");
      @(negedge Reloj);
      chk('0, "reset_held");
      @(posedge Reloj); #1;
      Reiniciar = 1'b1;

      run(16'h0000, 99, "alu0");
      run(16'h3298, 99, "alu3");
      run(16'h8A80, 99, "ld");
      run(16'h9058, 99, "st");
      run(16'hA100, 99, "jmp");

      for (int i = 0; i < 40; i++) begin
         ir = 16'($urandom);
         ir[15:12] = 4'($urandom_range(0, 14));
         run(ir, 99, "rand");
      end

      // Reset while the store is in GUARDA1: no WR cycle may follow
      run(16'h9058, 3, "st_rst");
      Instruccion = 16'h9058;
      #1;
      chk(exp_vec(3, 16'h9058), "st_guarda1");
      Reiniciar = 1'b0;
      #1;
      chk('0, "rst_async_out");
      @(negedge Reloj);
      chk('0, "rst_low_negedge");
      @(posedge Reloj); #1;
      chk('0, "rst_low_after_edge");
      Reiniciar = 1'b1;
      #1;
      chk(exp_vec(0, 16'h0000), "rst_release_busca0");
      run(16'h5A28, 99, "after_rst");

      // Halt and stay halted regardless of IR
      run(16'hF000, 99, "hlt");
      for (int i = 0; i < 10; i++) begin
         Instruccion = 16'($urandom);
         @(negedge Reloj);
         chk(halted, $sformatf("alto_%0d", i));
         @(posedge Reloj); #1;
      end

      Reiniciar = 1'b0;
      #1;
      chk('0, "alto_rst_async");
      @(posedge Reloj); #1;
      chk('0, "alto_rst_edge");
      Reiniciar = 1'b1;
      #1;
      chk(exp_vec(0, 16'h0000), "alto_rst_release");
      run(16'h1248, 99, "post_halt");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
